pwm_led_controller: RTL and testbench

Parametrised multi-channel PWM LED driver; successor to the fixed 3-channel, 8-bit RGB controller and its separate brightness stage. Generates CHANNELS independent PWM outputs of RES-bit resolution. Duty values load glitch-free at period boundaries, a global frame-skipping brightness dimmer is built in, and output polarity is selectable for anode or cathode wiring. Sits between colour/pattern logic and the LED pins.

---
 rtl/pwm_led_pkg.sv | 25 ++
 rtl/pwm_led_channel.sv | 51 +++++
 rtl/pwm_led_controller.sv | 76 +++++++
 tb/tb_pwm_led_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_led_pkg.sv
// Shared constants and helper functions for the multi-channel PWM LED driver.
// PWM_LED_PHASE_STAGGER_EN uses phase_offset() to spread channel turn-on edges.
package pwm_led_pkg;

    localparam int DEF_CHANNELS = 3;
    localparam int DEF_RES      = 8;
    localparam int DEF_BRIGHT_W = 3;

    // All-ones duty for a given resolution (RES <= 16).
    function automatic logic [15:0] max_duty(input int res);
        logic [31:0] full;
        full = (32'd1 << res) - 32'd1;
        return full[15:0];
    endfunction

    // Phase offset of channel k: k * (2^res / channels), truncated to res bits.
    function automatic logic [15:0] phase_offset(input int k, input int channels, input int res);
        logic [31:0] span;
        logic [31:0] ofs;
        span = 32'd1 << res;
        ofs  = (32'(k) * (span / 32'(channels))) % span;
        return ofs[15:0];
    endfunction

endpackage

// File: rtl/pwm_led_channel.sv
// One PWM channel: duty shadow register, comparator and registered active flag.
// PWM_LED_PHASE_STAGGER_EN shifts this channel's compare phase by its index.
module pwm_led_channel
    import pwm_led_pkg::*;
#(
    parameter int RES      = DEF_RES,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IDX      = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           run,
    input  logic           blank,
    input  logic [RES-1:0] cnt,
    input  logic [RES-1:0] duty,
    output logic           act
);

    localparam logic [15:0] MAX_W = max_duty(RES);
    localparam logic [RES-1:0] MAX = MAX_W[RES-1:0];
`ifdef PWM_LED_PHASE_STAGGER_EN
    localparam logic [15:0] OFS_W = phase_offset(IDX, CHANNELS, RES);
`else
    localparam logic [15:0] OFS_W = 16'd0;
`endif
    localparam logic [RES-1:0] OFFSET = OFS_W[RES-1:0];

    logic [RES-1:0] duty_reg;
    logic [RES-1:0] cmp;
    logic           on;

    assign cmp = cnt + OFFSET;

    always_comb begin
        on = (duty_reg == MAX) || (cmp < duty_reg);
    end

    // Shadow tracks duty_i during reset so the first period after release
    // already runs with the duty presented while reset was held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_reg <= duty;
            act      <= 1'b0;
        end else begin
            if (load) duty_reg <= duty;
            act <= on & ~blank & run;
        end
    end

endmodule

// File: rtl/pwm_led_controller.sv
// Multi-channel PWM LED driver with frame-skipping brightness and polarity select.
// Optional build macro: PWM_LED_PHASE_STAGGER_EN (per-channel phase stagger).
module pwm_led_controller
    import pwm_led_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int RES      = DEF_RES,
    parameter int BRIGHT_W = DEF_BRIGHT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    an,
    input  logic [CHANNELS*RES-1:0] duty_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    output logic [CHANNELS-1:0]     led_o,
    output logic                    sync,
    output logic                    half,
    output logic [BRIGHT_W-1:0]     frame_o
);

    localparam logic [15:0] MAX_W = max_duty(RES);
    localparam logic [RES-1:0] MAX = MAX_W[RES-1:0];

    logic [RES-1:0]      cnt;
    logic [BRIGHT_W-1:0] frm;
    logic [BRIGHT_W-1:0] bright_reg;
    logic                wrap;
    logic                load;
    logic                blank;
    logic [CHANNELS-1:0] act;

    assign wrap  = (cnt == MAX);
    assign load  = wrap | ~en_i;
    assign blank = (frm > bright_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            frm        <= '0;
            bright_reg <= '0;
        end else if (!en_i) begin
            cnt        <= '0;
            frm        <= '0;
            bright_reg <= bright_i;
        end else begin
            cnt <= cnt + 1'b1;
            if (wrap) frm <= frm + 1'b1;
            if (load) bright_reg <= bright_i;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_led_channel #(
            .RES      (RES),
            .CHANNELS (CHANNELS),
            .IDX      (k)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .run   (en_i),
            .blank (blank),
            .cnt   (cnt),
            .duty  (duty_i[k*RES +: RES]),
            .act   (act[k])
        );
    end

    // Polarity applied after the flop so an flips the pins immediately.
    assign led_o   = act ^ {CHANNELS{an}};
    assign sync    = (cnt == '0);
    assign half    = cnt[RES-1];
    assign frame_o = frm;

endmodule

// File: tb/tb_pwm_led_controller.sv
// Scoreboard bench for pwm_led_controller: per-period on-time counts plus directed edge checks.
// Build with PWM_LED_PHASE_STAGGER_EN defined to exercise the staggered-phase variant.
module tb_pwm_led_controller;

    localparam int CH  = 3;
    localparam int RES = 8;
    localparam int BW  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic              an;
    logic [CH*RES-1:0] duty_i;
    logic [BW-1:0]     bright_i;
    logic [CH-1:0]     led_o;
    logic              sync;
    logic              half;
    logic [BW-1:0]     frame_o;

    pwm_led_controller #(.CHANNELS(CH), .RES(RES), .BRIGHT_W(BW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .an       (an),
        .duty_i   (duty_i),
        .bright_i (bright_i),
        .led_o    (led_o),
        .sync     (sync),
        .half     (half),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c0;
        int c1;
        int c2;
        int frame;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic go_to(input int n);
        while (edge_n < n) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    // Monitor: a period window at the pins spans cnt=1..255 plus the following cnt=0
    // sample; it closes on sync rising. Samples while sync stays high are discarded.
    int       acc [CH];
    logic     prev_sync = 1'b1;
    logic [CH-1:0] a_now;
    exp_t     e;

    always @(negedge clk) begin
        a_now = led_o ^ {CH{an}};
        if (sync && !prev_sync) begin
            for (int k = 0; k < CH; k++) acc[k] += int'(a_now[k]);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got window with no expectation (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("on_cnt_ch0", acc[0], e.c0);
                chk("on_cnt_ch1", acc[1], e.c1);
                chk("on_cnt_ch2", acc[2], e.c2);
                chk("frame_at_sync", int'(frame_o), e.frame);
            end
            for (int k = 0; k < CH; k++) acc[k] = 0;
        end else if (sync) begin
            for (int k = 0; k < CH; k++) acc[k] = 0;
        end else begin
            for (int k = 0; k < CH; k++) acc[k] += int'(a_now[k]);
        end
        prev_sync = sync;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < CH; k++) acc[k] = 0;
        an       = 1'b1;
        rst      = 1'b0;
        en_i     = 1'b1;
        duty_i   = {8'd255, 8'd64, 8'd0};
        bright_i = 3'd7;
        repeat (3) @(negedge clk);
        chk("reset_led_an1", int'(led_o), 3'b111);
        chk("reset_sync", int'(sync), 1);
        chk("reset_half", int'(half), 0);
        chk("reset_frame", int'(frame_o), 0);
        an = 1'b0;
        #1;
        chk("reset_led_an0", int'(led_o), 3'b000);

        // Period windows: P0..P2 lit, shadow change lands in P2, bright=1 blanks
        // frames 3..7 and frame 2 of the next dimming cycle, P11 cut short by en_i.
        sb.push_back('{0, 64, 256, 1});
        sb.push_back('{0, 64, 256, 2});
        sb.push_back('{0, 200, 256, 3});
        sb.push_back('{0, 0, 0, 4});
        sb.push_back('{0, 0, 0, 5});
        sb.push_back('{0, 0, 0, 6});
        sb.push_back('{0, 0, 0, 7});
        sb.push_back('{0, 0, 0, 0});
        sb.push_back('{0, 200, 256, 1});
        sb.push_back('{0, 200, 256, 2});
        sb.push_back('{0, 0, 0, 3});
        sb.push_back('{0, 50, 50, 0});
        sb.push_back('{0, 128, 256, 1});

        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;

`ifndef PWM_LED_PHASE_STAGGER_EN
        go_to(1);   chk("led_cnt1", int'(led_o), 3'b110);
        chk("sync_cnt1", int'(sync), 0);
        go_to(64);  chk("led_cnt64", int'(led_o), 3'b110);
        go_to(65);  chk("led_cnt65", int'(led_o), 3'b100);
`else
        go_to(1);   chk("sync_cnt1", int'(sync), 0);
        go_to(171); chk("led_cnt171", int'(led_o), 3'b100);
        go_to(172); chk("led_cnt172", int'(led_o), 3'b110);
`endif
        go_to(127); chk("half_cnt127", int'(half), 0);
        go_to(128); chk("half_cnt128", int'(half), 1);
        go_to(256); chk("sync_wrap", int'(sync), 1);
        chk("frame_wrap1", int'(frame_o), 1);
        chk("led_cnt0", int'(led_o), 3'b100);

        go_to(356);
        chk("led_p1_cnt100", int'(led_o), 3'b100);
        duty_i[15:8] = 8'd200;

        go_to(700);
        bright_i = 3'd1;

        go_to(2600);
        chk("led_dark_frame2", int'(led_o), 3'b000);
        chk("frame_p10", int'(frame_o), 2);
        chk("sync_midperiod", int'(sync), 0);
        bright_i = 3'd7;

        go_to(2866);
        en_i = 1'b0;
        duty_i[15:8] = 8'd128;
        go_to(2867);
        chk("en_off_led", int'(led_o), 3'b000);
        chk("en_off_sync", int'(sync), 1);
        chk("en_off_frame", int'(frame_o), 0);
        go_to(2870);
        chk("en_off_hold_led", int'(led_o), 3'b000);
        go_to(2871);
        en_i = 1'b1;

        go_to(2950);
`ifndef PWM_LED_PHASE_STAGGER_EN
        chk("led_an0_cnt79", int'(led_o), 3'b110);
        #2 an = 1'b1;
        #1 chk("led_an1_cnt79", int'(led_o), 3'b001);
`else
        chk("led_an0_cnt79", int'(led_o), 3'b100);
        #2 an = 1'b1;
        #1 chk("led_an1_cnt79", int'(led_o), 3'b011);
`endif

        go_to(3130);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
